// File: rtl/hazard_stall_ctrl_if.sv
// D-stage decode bundle and interlock controls of hazard_stall_ctrl.
// master drives decode info, slave is the interlock controller.
interface hazard_stall_ctrl_if;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [2:0] res_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] dst_d;
  logic       md_start_d;
  logic       md_is_div_d;
  logic       md_use_d;
  logic       flush;
  logic       stall;
  logic       en_pc;
  logic       en_d;
  logic       clr_e;
  logic       md_busy;
  logic [4:0] dst_e;
  logic [4:0] dst_m;
  logic [1:0] tnew_e;
  logic [1:0] tnew_m;

  modport master (
    output tuse_rs, tuse_rt, res_d,
    output rs_d, rt_d, dst_d,
    output md_start_d, md_is_div_d,
    output md_use_d, flush,
    input  stall, en_pc, en_d, clr_e,
    input  md_busy, dst_e, dst_m,
    input  tnew_e, tnew_m
  );

  modport slave (
    input  tuse_rs, tuse_rt, res_d,
    input  rs_d, rt_d, dst_d,
    input  md_start_d, md_is_div_d,
    input  md_use_d, flush,
    output stall, en_pc, en_d, clr_e,
    output md_busy, dst_e, dst_m,
    output tnew_e, tnew_m
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// 5-stage MIPS interlock: Tuse/Tnew shadow pipe plus HI/LO busy counter.
// Define HAZ_STALL_STAT_EN to add stall_cnt / md_stall_cnt statistics.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset_n,
  hazard_stall_ctrl_if.slave bus
`ifdef HAZ_STALL_STAT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);
  localparam logic [2:0] RES_NW  = 3'd0;
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD =
    CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD =
    CW'(DIV_CYCLES);

  logic [4:0]    dst_e_q, dst_m_q;
  logic [1:0]    tnew_e_q, tnew_m_q;
  logic          md_e_q, md_div_q;
  logic [CW-1:0] md_cnt_q;

  logic [1:0] tnew_d;
  logic [4:0] dst_in;
  logic       rs_haz, rt_haz, md_haz;
  logic       stall, issue, md_busy;

  always_comb begin
    tnew_d = 2'd0;
    dst_in = bus.dst_d;
    unique case (1'b1)
      bus.res_d == RES_ALU: tnew_d = 2'd1;
      bus.res_d == RES_DM:  tnew_d = 2'd2;
      bus.res_d == RES_NW:  dst_in = 5'd0;
      default: ;
    endcase
  end

  // $0 is excluded on the consumer side
  assign rs_haz =
    (bus.rs_d != 5'd0) &&
    (bus.tuse_rs != 2'd3) &&
    ((bus.rs_d == dst_e_q &&
      tnew_e_q > bus.tuse_rs) ||
     (bus.rs_d == dst_m_q &&
      tnew_m_q > bus.tuse_rs));

  assign rt_haz =
    (bus.rt_d != 5'd0) &&
    (bus.tuse_rt != 2'd3) &&
    ((bus.rt_d == dst_e_q &&
      tnew_e_q > bus.tuse_rt) ||
     (bus.rt_d == dst_m_q &&
      tnew_m_q > bus.tuse_rt));

  assign md_busy = (md_cnt_q != '0);
  assign md_haz  = bus.md_use_d &
                   (md_busy | md_e_q);
  assign stall   = rs_haz | rt_haz | md_haz;
  assign issue   = ~stall & ~bus.flush;

  assign bus.stall   = stall;
  assign bus.en_pc   = ~stall;
  assign bus.en_d    = ~stall;
  assign bus.clr_e   = stall | bus.flush;
  assign bus.md_busy = md_busy;
  assign bus.dst_e   = dst_e_q;
  assign bus.dst_m   = dst_m_q;
  assign bus.tnew_e  = tnew_e_q;
  assign bus.tnew_m  = tnew_m_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_e_q  <= 5'd0;
      tnew_e_q <= 2'd0;
      dst_m_q  <= 5'd0;
      tnew_m_q <= 2'd0;
    end else begin
      dst_m_q  <= dst_e_q;
      tnew_m_q <= (tnew_e_q != 2'd0) ?
                  tnew_e_q - 2'd1 : 2'd0;
      if (issue) begin
        dst_e_q  <= dst_in;
        tnew_e_q <= tnew_d;
      end else begin
        dst_e_q  <= 5'd0;
        tnew_e_q <= 2'd0;
      end
    end
  end

  // a flush while the md op sits in E cancels it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_e_q   <= 1'b0;
      md_div_q <= 1'b0;
      md_cnt_q <= '0;
    end else begin
      md_e_q <= issue & bus.md_start_d;
      if (issue)
        md_div_q <= bus.md_is_div_d;
      if (md_e_q && !bus.flush)
        md_cnt_q <= md_div_q ? DIV_LD : MULT_LD;
      else if (md_busy)
        md_cnt_q <= md_cnt_q - CW'(1);
    end
  end

`ifdef HAZ_STALL_STAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt    <= 32'd0;
      md_stall_cnt <= 32'd0;
    end else begin
      if (stall)
        stall_cnt <= stall_cnt + 32'd1;
      if (md_haz)
        md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
